instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the combinational instruction memory.
//  - Owns the program counter and drives the word address into the memory.
//  - Captures the returned instruction into an IF/ID register.
//  - Hands the instruction to decode over a valid/ready handshake.
//  - Handles control-flow redirects (branch/jump) and decode back-pressure.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; reset value of if_instr
// PORTS
//  clk             in   1   single clock, all state updates on rising edge
//  reset           in   1   synchronous, active-high reset
//  fetch_en        in   1   1 = fetch may advance; 0 = no new fetches
//  imem_addr       out  32  byte address to instruction memory (= pc)
//  imem_rdata      in   32  instruction from memory, combinational from imem_addr
//  redirect_valid  in   1   take redirect_pc this cycle (branch/jump resolved)
//  redirect_pc     in   32  redirect target byte address
//  if_valid        out  1   IF/ID register holds a valid instruction
//  id_ready        in   1   decode accepts the IF/ID contents this cycle
//  if_instr        out  32  fetched instruction
//  if_pc           out  32  PC of if_instr
//  if_pc_plus4     out  32  if_pc + 4, registered, wraps mod 2^32
//  misalign_err    out  1   sticky; set by a redirect with redirect_pc[1:0] != 0
//  fetch_count     out  32  number of instructions loaded into IF/ID, wraps
// BEHAVIOUR
//  - Reset values:
//    - pc = RESET_PC, if_valid = 0, if_instr = NOP_INSTR.
//    - if_pc = RESET_PC, if_pc_plus4 = RESET_PC + 4.
//    - misalign_err = 0, fetch_count = 0.
//    - Reset applies mid-operation, overrides every other input, and clears misalign_err.
//  - imem_addr = pc (direct wire from register). Memory is combinational; zero-cycle latency.
//  - accept = !if_valid || id_ready (IF/ID empty or being drained).
//  - Priority each edge: reset > redirect_valid > accept && fetch_en > hold.
//  - Redirect:
//    - pc <= {redirect_pc[31:2], 2'b00}; if_valid <= 0 (one-bubble flush).
//    - Applies even while decode is stalled or fetch_en = 0; the in-flight IF/ID entry is discarded.
//    - If redirect_pc[1:0] != 0, misalign_err <= 1 and the PC is still forced aligned.
//    - fetch_count is unchanged.
//  - Fetch (accept && fetch_en && !redirect_valid):
//    - if_instr <= imem_rdata; if_pc <= pc; if_pc_plus4 <= pc + 4; if_valid <= 1.
//    - pc <= pc + 4; 32'hFFFF_FFFC wraps to 0.
//    - fetch_count <= fetch_count + 1.
//  - Drain (accept && !fetch_en && !redirect_valid):
//    - if_valid <= 0; pc and payload hold.
//  - Hold (if_valid && !id_ready, no redirect):
//    - pc, if_valid, if_instr, if_pc and if_pc_plus4 are all stable. Payload must not change while valid && !ready.
//  - Throughput: one instruction per cycle when id_ready is held high.
//  - First valid instruction appears the cycle after reset deasserts.
//  - Redirect-to-valid latency: 1 cycle.
// STRUCTURE
//  - Shared package riscv_pkg holds XLEN = 32, NOP_INSTR, RESET_VECTOR and the IF/ID struct typedef if_id_t {instr, pc, pc_plus4}.
//  - One sub-module pc_register: PC flop with load, increment and hold controls.
//  - Handshake logic and IF/ID register stay in this module.
// TESTING
//  - Reset then free-run (id_ready = 1, fetch_en = 1) against a 4-word memory:
//    - if_pc = 0, 4, 8, 12 on consecutive cycles.
//    - if_instr matches memory; fetch_count = 4.
//  - Back-pressure: id_ready = 0 for 3 cycles while if_pc = 8:
//    - if_pc and if_instr hold 3 cycles, pc holds at 12.
//    - Resume gives if_pc = 12 next cycle.
//  - Redirect to 32'h40 while stalled:
//    - Next cycle if_valid = 0, imem_addr = 32'h40.
//    - Following cycle if_pc = 32'h40, if_valid = 1.
//  - Redirect to 32'h42:
//    - misalign_err = 1 and stays 1; imem_addr = 32'h40.
//    - Reset clears misalign_err to 0.
//  - Wrap: RESET_PC = 32'hFFFF_FFFC:
//    - First if_pc = 32'hFFFF_FFFC, if_pc_plus4 = 0.
//    - Next if_pc = 0.
//  - fetch_en = 0 with id_ready = 1: if_valid falls to 0 after one drain, fetch_count stops.
//  - Reset asserted mid-stream: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and the IF/ID payload type
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter flop with word-aligned load, increment and hold
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [29:0] load_word,
  input  logic        inc,
  output logic [31:0] pc
);

  // Load takes a word index, so the loaded PC is aligned by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {load_word, 2'b00};
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, IF/ID register and decode handshake
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  import riscv_pkg::*;

  logic        accept;
  logic        do_fetch;
  logic [31:0] pc;
  if_id_t      if_id_q;
  logic        if_valid_q;
  logic        misalign_q;
  logic [31:0] count_q;

  assign accept   = !if_valid_q || id_ready;
  assign do_fetch = accept && fetch_en && !redirect_valid;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (redirect_valid),
    .load_word (redirect_pc[31:2]),
    .inc       (do_fetch),
    .pc        (pc)
  );

  // Redirect drops the in-flight entry; payload is only written on a real fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      if_id_q    <= '{instr: NOP_INSTR, pc: RESET_PC, pc_plus4: RESET_PC + 32'd4};
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else if (redirect_valid) begin
      if_valid_q <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end else if (accept) begin
      if_valid_q <= fetch_en;
      if (fetch_en) begin
        if_id_q <= '{instr: imem_rdata, pc: pc, pc_plus4: pc + 32'd4};
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_addr    = pc;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_id_q.instr;
  assign if_pc        = if_id_q.pc;
  assign if_pc_plus4  = if_id_q.pc_plus4;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - bench for instruction_fetch_unit: vector table, wrap/reset sequences, random vs model
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, id_ready;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4, fetch_count;
  logic        if_valid, misalign_err;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4, w_count;
  logic        w_valid, w_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = memf(imem_addr);
  assign w_rdata    = memf(w_addr);

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(w_valid), .id_ready(id_ready),
    .if_instr(w_instr), .if_pc(w_pc), .if_pc_plus4(w_pc4), .misalign_err(w_mis),
    .fetch_count(w_count)
  );

  // Reference model of the default-parameter DUT's architectural state.
  logic [31:0] m_pc, m_instr, m_ipc, m_pc4, m_cnt;
  logic        m_v, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic fe, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    logic [31:0] mem_word;
    reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    mem_word = memf(m_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h13; m_ipc = 32'h0; m_pc4 = 32'h4;
      m_mis = 1'b0; m_cnt = 32'h0;
    end else if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_v = 1'b0;
      if (rpc % 4 != 0) m_mis = 1'b1;
    end else if (!m_v || rdy) begin
      if (fe) begin
        m_instr = mem_word; m_ipc = m_pc; m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_v = 1'b1; m_cnt = m_cnt + 32'd1;
      end else begin
        m_v = 1'b0;
      end
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pc_plus4", if_pc_plus4, m_pc4);
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  typedef struct {
    logic        rst, fe, rv, rdy;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] ipc, addr, cnt;
    logic        mis;
  } vec_t;

  vec_t tbl[17];

  initial begin
    //              rst fe rv rdy rpc        v  if_pc  addr   cnt mis
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0,  32'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'h0,  32'h4,  32'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'h4,  32'h8,  32'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'h8,  32'hC,  32'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC,  32'd3, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC,  32'd3, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC,  32'd3, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'hC,  32'h10, 32'd4, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  32'h10, 32'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'hC,  32'h40, 32'd4, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'h44, 32'd5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h42, 1'b0, 32'h40, 32'h40, 32'd5, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h40, 32'h40, 32'd5, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'h40, 32'h44, 32'd6, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h40, 32'h44, 32'd6, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h40, 32'h44, 32'd6, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0,  32'd0, 1'b0};

    m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h13; m_ipc = 32'h0; m_pc4 = 32'h4;
    m_mis = 1'b0; m_cnt = 32'h0;

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].v});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_count", i), fetch_count, tbl[i].cnt);
      chk($sformatf("vec%0d_mis", i), {31'd0, misalign_err}, {31'd0, tbl[i].mis});
      if (tbl[i].v) chk($sformatf("vec%0d_if_pc", i), if_pc, tbl[i].ipc);
    end
    chk("reset_instr", if_instr, 32'h0000_0013);

    // PC wrap on the instance reset at the top of the address space.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_reset_pc4", w_pc4, 32'h0);
    chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_first_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_first_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_first_pc4", w_pc4, 32'h0);
    chk("wrap_first_instr", w_instr, memf(32'hFFFF_FFFC));
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_next_pc", w_pc, 32'h0);
    chk("wrap_next_pc4", w_pc4, 32'h4);
    chk("wrap_count", w_count, 32'd2);
    chk("wrap_mis", {31'd0, w_mis}, 32'd0);

    // Randomized traffic against the model, including high-address redirects.
    for (int n = 0; n < 3000; n++) begin
      logic rst, fe, rv, rdy;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 149) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      fe  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h0000_01FF);
      cycle(rst, fe, rv, rpc, rdy);
    end

    // Mid-stream reset after fresh traffic and a misaligned redirect.
    cycle(1'b0, 1'b1, 1'b1, 32'h101, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("midreset_valid", {31'd0, if_valid}, 32'd0);
    chk("midreset_instr", if_instr, 32'h0000_0013);
    chk("midreset_pc", if_pc, 32'h0);
    chk("midreset_pc4", if_pc_plus4, 32'h4);
    chk("midreset_mis", {31'd0, misalign_err}, 32'd0);
    chk("midreset_count", fetch_count, 32'd0);
    chk("midreset_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
